rob_alloc_manager: RTL and testbench
====================================

Name: rob_alloc_manager

Overview:
Parametrised ROB entry allocator for the dispatch stage. It tracks head (oldest) and tail (next free) pointers plus an occupancy count. Each cycle it grants up to DP_WIDTH entries per dispatch group and frees up to COM_WIDTH entries at commit. It also supports flush recovery (tail rollback on mispredict) and drives full/empty/occupancy status to dispatch and commit logic.

Parameters:
DEPTH, 64, ROB entries; power of 2, >= 4.
DP_WIDTH, 2, dispatch lanes per cycle; 1..4.
COM_WIDTH, 2, max commits per cycle; 1..4.
PTR_W (localparam), clog2(DEPTH), entry pointer width.
CNT_W (localparam), clog2(DEPTH)+1, occupancy width (holds DEPTH).
DPN_W / COMN_W (localparam), clog2(DP_WIDTH+1) / clog2(COM_WIDTH+1).

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
i_stall  in  1  downstream stall; blocks dispatch acceptance
i_dp_vld  in  DP_WIDTH  per-lane dispatch request; holes allowed
i_com_num  in  COMN_W  entries retired this cycle (0..COM_WIDTH)
i_flush  in  1  mispredict recovery strobe
i_flush_ptr  in  PTR_W  first entry to discard (new tail)
o_allocable  out  1  whole dispatch group fits
o_dp_fire  out  1  group accepted this cycle
o_dp_ptr  out  DP_WIDTH*PTR_W  lane k entry at bits [k*PTR_W +: PTR_W]
o_head_ptr  out  PTR_W  oldest occupied entry
o_used_num  out  CNT_W  occupied entries
o_full  out  1  used == DEPTH
o_empty  out  1  used == 0

Behaviour:
- State: head, tail (PTR_W), used (CNT_W). Reset: head=0, tail=0, used=0, so o_full=0 and o_empty=1. Reset overrides flush, dispatch and commit in the same cycle.
- dp_num = popcount(i_dp_vld), width DPN_W.
- Lane pointer: o_dp_ptr[k] = tail + popcount(i_dp_vld[k-1:0]) mod DEPTH. Invalid lanes carry their prefix value (deterministic, ignored downstream). All lane pointers are combinational from tail and i_dp_vld.
- o_allocable = (DEPTH - used + i_com_num) >= dp_num. Same-cycle commit credit applies. Computed at CNT_W+1 bits with no overflow. All-or-nothing: no partial group grant.
- o_dp_fire = o_allocable & ~i_stall & ~i_flush & (dp_num != 0). Gated internally, so no outside coupling is required.
- Commit (every non-reset cycle, including flush and stall): head_nxt = head + i_com_num mod DEPTH.
- Normal update (no flush): tail += o_dp_fire ? dp_num : 0; used = used - i_com_num + (o_dp_fire ? dp_num : 0).
- Flush update: tail = i_flush_ptr; used = (i_flush_ptr - head_nxt) mod DEPTH, zero-extended to CNT_W. Same-cycle dispatch is dropped.
- Flush precondition: i_flush_ptr lies in the occupied window after commit, or equals head_nxt (flush-all, giving used=0). A flush therefore never yields used == DEPTH.
- Pointer wrap is natural modulo DEPTH; no wrap bit is needed since used disambiguates full vs empty.
- Illegal inputs, flagged by bench assertions only (behaviour undefined): i_com_num > used; i_com_num > COM_WIDTH; i_flush_ptr outside the window.
- o_head_ptr, o_used_num, o_full, o_empty are registered state (decoded from used). Latency: a dispatch or commit is visible on status the next cycle.
- Simultaneous dispatch and commit in a full ROB: allowed when i_com_num >= dp_num; used stays at DEPTH if equal.

Test Plan:
(Bench overrides DEPTH=8, DP_WIDTH=2, COM_WIDTH=2.)
1. Reset, then i_dp_vld=2'b11, no stall -> o_dp_ptr={1,0}, o_dp_fire=1; next cycle tail=2, used=2, o_empty=0.
2. i_dp_vld=2'b10 with tail=5 -> lane0 ptr=5 (invalid), lane1 ptr=5; after fire tail=6, used += 1.
3. Fill to used=8 (o_full=1), i_dp_vld=2'b11, i_com_num=0 -> o_allocable=0, o_dp_fire=0. Same with i_com_num=2 -> fire; used stays 8, head +2, tail +2 mod 8.
4. Wrap: head=6, tail=6, used=0; dispatch 2 per cycle for 3 cycles -> lane pointers 6,7,0,1,2,3; tail=4, used=6.
5. head=2, tail=7, used=5; i_flush=1, i_flush_ptr=4, i_com_num=1, i_dp_vld=2'b11 -> o_dp_fire=0; next cycle head=3, tail=4, used=1.
6. Mid-operation rst_n=0 coinciding with i_flush and a fire-able dispatch -> next cycle head=tail=0, used=0, o_empty=1.

Source files
------------

// File: rtl/rob_alloc_manager.sv
`default_nettype none
// rob_alloc_manager: ROB head/tail/occupancy tracker for the dispatch stage.
// Grants whole dispatch groups, retires commits and rolls the tail back on flush.
module rob_alloc_manager #(
   parameter  int DEPTH     = 64,
   parameter  int DP_WIDTH  = 2,
   parameter  int COM_WIDTH = 2,
   localparam int PTR_W     = $clog2(DEPTH),
   localparam int CNT_W     = $clog2(DEPTH) + 1,
   localparam int DPN_W     = $clog2(DP_WIDTH + 1),
   localparam int COMN_W    = $clog2(COM_WIDTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_stall,
   input  logic [DP_WIDTH-1:0]       i_dp_vld,
   input  logic [COMN_W-1:0]         i_com_num,
   input  logic                      i_flush,
   input  logic [PTR_W-1:0]          i_flush_ptr,
   output logic                      o_allocable,
   output logic                      o_dp_fire,
   output logic [DP_WIDTH*PTR_W-1:0] o_dp_ptr,
   output logic [PTR_W-1:0]          o_head_ptr,
   output logic [CNT_W-1:0]          o_used_num,
   output logic                      o_full,
   output logic                      o_empty
);

   localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] used;
   logic [PTR_W-1:0] head_nxt;
   logic [PTR_W-1:0] flush_used;
   logic [DPN_W-1:0] dp_num;
   logic [CNT_W:0]   free_credit;

   // Each lane gets tail plus the number of valid lanes below it; dp_num
   // ends up as the popcount of the whole request vector.
   always_comb begin
      dp_num   = '0;
      o_dp_ptr = '0;
      for (int k = 0; k < DP_WIDTH; k++) begin
         o_dp_ptr[k*PTR_W +: PTR_W] = tail + PTR_W'(dp_num);
         dp_num                     = dp_num + DPN_W'(i_dp_vld[k]);
      end
   end

   // One extra bit keeps DEPTH - used + commit credit from overflowing.
   assign free_credit = DEPTH_EXT - {1'b0, used} + (CNT_W + 1)'(i_com_num);
   assign o_allocable = (free_credit >= (CNT_W + 1)'(dp_num));
   assign o_dp_fire   = o_allocable & ~i_stall & ~i_flush & (dp_num != '0);

   assign head_nxt    = head + PTR_W'(i_com_num);
   assign flush_used  = i_flush_ptr - head_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         used <= '0;
      end else begin
         head <= head_nxt;
         if (i_flush) begin
            tail <= i_flush_ptr;
            used <= {1'b0, flush_used};
         end else begin
            tail <= tail + (o_dp_fire ? PTR_W'(dp_num) : '0);
            used <= used - CNT_W'(i_com_num) + (o_dp_fire ? CNT_W'(dp_num) : '0);
         end
      end
   end

   assign o_head_ptr = head;
   assign o_used_num = used;
   assign o_full     = (used == CNT_W'(DEPTH));
   assign o_empty    = (used == '0);

endmodule
`default_nettype wire

// File: tb/tb_rob_alloc_manager.sv
`default_nettype none
// tb_rob_alloc_manager: directed test-plan steps followed by random legal traffic,
// each cycle compared against a head/occupancy reference model.
module tb_rob_alloc_manager;

   localparam int DEPTH = 8;
   localparam int DPW   = 2;
   localparam int CMW   = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       stall;
   logic [1:0] dp_vld;
   logic [1:0] com_num;
   logic       flush;
   logic [2:0] flush_ptr;
   logic       allocable;
   logic       dp_fire;
   logic [5:0] dp_ptr;
   logic [2:0] head_ptr;
   logic [3:0] used_num;
   logic       full;
   logic       empty;

   int passed = 0;
   int total  = 0;

   // Reference model: oldest entry and occupancy; tail is always head + used.
   int m_head = 0;
   int m_used = 0;

   rob_alloc_manager #(.DEPTH(DEPTH), .DP_WIDTH(DPW), .COM_WIDTH(CMW)) dut (
      .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_dp_vld(dp_vld),
      .i_com_num(com_num), .i_flush(flush), .i_flush_ptr(flush_ptr),
      .o_allocable(allocable), .o_dp_fire(dp_fire), .o_dp_ptr(dp_ptr),
      .o_head_ptr(head_ptr), .o_used_num(used_num), .o_full(full), .o_empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int m_tail();
      return (m_head + m_used) % DEPTH;
   endfunction

   task automatic check_state(input string tag);
      chk({tag, ":head"},  32'(head_ptr),     32'(m_head));
      chk({tag, ":used"},  32'(used_num),     32'(m_used));
      chk({tag, ":full"},  32'(full),         32'(m_used == DEPTH));
      chk({tag, ":empty"}, 32'(empty),        32'(m_used == 0));
      chk({tag, ":tail"},  32'(dp_ptr[2:0]),  32'(m_tail()));
   endtask

   // One clocked step: drive inputs, check combinational outputs, clock, check state.
   task automatic step(input string tag, input logic st, input logic [1:0] vld,
                       input int com, input logic fl, input int fp);
      int  n;
      int  hn;
      bit  e_alloc;
      bit  e_fire;
      stall = st; dp_vld = vld; com_num = 2'(com); flush = fl; flush_ptr = 3'(fp);
      #2;
      n       = $countones(vld);
      e_alloc = (DEPTH - m_used + com) >= n;
      e_fire  = e_alloc && !st && !fl && (n != 0);
      chk({tag, ":alloc"}, 32'(allocable),   32'(e_alloc));
      chk({tag, ":fire"},  32'(dp_fire),     32'(e_fire));
      chk({tag, ":lane0"}, 32'(dp_ptr[2:0]), 32'(m_tail()));
      chk({tag, ":lane1"}, 32'(dp_ptr[5:3]), 32'((m_tail() + int'(vld[0])) % DEPTH));
      @(posedge clk);
      #1;
      hn = (m_head + com) % DEPTH;
      if (fl) m_used = (fp - hn + DEPTH) % DEPTH;
      else    m_used = m_used - com + (e_fire ? n : 0);
      m_head = hn;
      check_state(tag);
   endtask

   task automatic do_reset(input string tag, input logic fl, input logic [1:0] vld);
      rst_n = 1'b0; stall = 1'b0; dp_vld = vld; com_num = 2'd0;
      flush = fl; flush_ptr = 3'd5;
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      m_head = 0;
      m_used = 0;
      check_state(tag);
   endtask

   initial begin
      int com;
      int fp;
      bit fl;
      do_reset("rst", 1'b0, 2'b00);

      // 1: two-lane dispatch from empty
      step("t1", 0, 2'b11, 0, 0, 0);
      chk("t1:used2", 32'(used_num), 32'd2);
      step("t1b", 0, 2'b11, 0, 0, 0);
      // 2: hole in lane 0 at tail=5
      step("t2a", 0, 2'b01, 0, 0, 0);
      chk("t2:tail5", 32'(dp_ptr[2:0]), 32'd5);
      step("t2", 0, 2'b10, 0, 0, 0);
      chk("t2:tail6", 32'(dp_ptr[2:0]), 32'd6);
      // 3: fill, then blocked and credit-assisted dispatch on a full ROB
      step("t3a", 0, 2'b11, 0, 0, 0);
      chk("t3:full", 32'(full), 32'd1);
      step("t3b", 0, 2'b11, 0, 0, 0);
      step("t3c", 0, 2'b11, 2, 0, 0);
      chk("t3:stay8", 32'(used_num), 32'd8);
      chk("t3:head2", 32'(head_ptr), 32'd2);

      // 4: wrap
      do_reset("r4", 1'b0, 2'b00);
      repeat (3) step("t4fill", 0, 2'b11, 0, 0, 0);
      repeat (3) step("t4drain", 0, 2'b00, 2, 0, 0);
      repeat (3) step("t4", 0, 2'b11, 0, 0, 0);
      chk("t4:tail4", 32'(dp_ptr[2:0]), 32'd4);
      chk("t4:used6", 32'(used_num), 32'd6);

      // 5: flush with same-cycle commit and dropped dispatch
      do_reset("r5", 1'b0, 2'b00);
      repeat (3) step("t5fill", 0, 2'b11, 0, 0, 0);
      step("t5fill1", 0, 2'b01, 0, 0, 0);
      step("t5drain", 0, 2'b00, 2, 0, 0);
      step("t5", 0, 2'b11, 1, 1, 4);
      chk("t5:head3", 32'(head_ptr), 32'd3);
      chk("t5:used1", 32'(used_num), 32'd1);

      // 6: reset beats flush and dispatch
      step("t6pre", 0, 2'b11, 0, 0, 0);
      do_reset("t6", 1'b1, 2'b11);

      // Random legal traffic
      for (int i = 0; i < 400; i++) begin
         com = $urandom_range(0, (m_used < CMW) ? m_used : CMW);
         fl  = ($urandom_range(0, 9) == 0);
         fp  = (m_head + com +
                $urandom_range(0, (m_used - com > 0) ? m_used - com - 1 : 0)) % DEPTH;
         step("rnd", ($urandom_range(0, 3) == 0), 2'($urandom), com, fl, fp);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
